// File: rtl/pulse_gap_meter.sv
// pulse_gap_meter: measures the gap in clk cycles between a rising edge on
// in_start and the next rising edge on in_stop. The result is held with a
// valid/ready handshake. A measurement that reaches TIMEOUT cycles ends early
// and is flagged with out_timeout.
module pulse_gap_meter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 254
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_start,
  input  logic             in_stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_count,
  output logic             out_timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t           state, state_nx;
  logic             start_prev, stop_prev;
  logic             start_edge, stop_edge;
  logic [WIDTH-1:0] counter, counter_nx, count_inc;
  logic [WIDTH-1:0] count_nx;
  logic             timeout_nx, valid_nx;

  // An edge exists only in the cycle where the level first reads high.
  // Edges that arrive in a state which does not use them are simply lost.
  assign start_edge = in_start & ~start_prev;
  assign stop_edge  = in_stop  & ~stop_prev;

  // counter stays below TIMEOUT, so the increment never wraps in WIDTH bits.
  assign count_inc  = counter + ONE;
  assign busy       = (state != IDLE);

  // Next-state and next-result logic. Everything holds its value by default.
  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    count_nx   = out_count;
    timeout_nx = out_timeout;
    valid_nx   = out_valid;
    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (start_edge) begin
          state_nx   = COUNT;
          counter_nx = '0;
        end
      end
      COUNT: begin
        // A stop edge takes priority over a simultaneous timeout.
        if (stop_edge) begin
          count_nx   = count_inc;
          timeout_nx = 1'b0;
          valid_nx   = 1'b1;
          state_nx   = HOLD;
        end else if (count_inc == LIMIT) begin
          count_nx   = LIMIT;
          timeout_nx = 1'b1;
          valid_nx   = 1'b1;
          state_nx   = HOLD;
        end else begin
          counter_nx = count_inc;
        end
      end
      HOLD: begin
        valid_nx = 1'b1;
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        valid_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // State, counter, result and edge-history registers. Reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      out_count   <= '0;
      out_timeout <= 1'b0;
      out_valid   <= 1'b0;
      start_prev  <= 1'b0;
      stop_prev   <= 1'b0;
    end else begin
      state       <= state_nx;
      counter     <= counter_nx;
      out_count   <= count_nx;
      out_timeout <= timeout_nx;
      out_valid   <= valid_nx;
      start_prev  <= in_start;
      stop_prev   <= in_stop;
    end
  end

endmodule

// File: doc/pulse_gap_meter.md
PULSE_GAP_METER -- requirements
Module: pulse_gap_meter

Interface
REQ-001 Parameter WIDTH, default 8, measurement counter and result width in bits.
REQ-002 Parameter TIMEOUT, default 254, maximum measurable gap in clk cycles; legal range 2 .. 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_start  input  1  start-event level, already synchronous to clk (e.g. FF2SyncP output).
REQ-006 in_stop  input  1  stop-event level, already synchronous to clk.
REQ-007 out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-008 out_valid  output  1  result available and held.
REQ-009 out_count  output  WIDTH  measured gap in clk cycles.
REQ-010 out_timeout  output  1  result ended by timeout, not by a stop event.
REQ-011 busy  output  1  high in COUNT and HOLD states.

Function
REQ-012 Rising-edge detection on in_start and in_stop SHALL use one registered previous-value flop each, updated every cycle in every state; an edge is (level==1 && prev==0).
REQ-013 A level held high SHALL produce exactly one edge; edges occurring in a state that does not consume them are discarded, not queued.
REQ-014 State machine SHALL have exactly three states: IDLE, COUNT, HOLD.
REQ-015 IDLE: on start edge -> COUNT, counter <= 0; stop edges ignored; start and stop edge in the same cycle -> start taken, stop dropped.
REQ-016 COUNT: on stop edge -> out_count <= counter+1, out_timeout <= 0, HOLD; else if counter+1 == TIMEOUT -> out_count <= TIMEOUT, out_timeout <= 1, HOLD; else counter <= counter+1.
REQ-017 Resulting out_count SHALL equal Ts-T0, where T0 is the posedge at which the start edge is sampled and Ts the posedge at which the stop edge is sampled; minimum 1.
REQ-018 Stop edge and timeout condition in the same cycle: stop wins, out_timeout=0, out_count=TIMEOUT.
REQ-019 Start edges during COUNT SHALL be ignored (no restart).
REQ-020 HOLD: out_valid=1; out_count and out_timeout stable; when out_valid && out_ready at posedge -> IDLE, out_valid 0 next cycle.
REQ-021 Start edges during HOLD, including the handshake cycle, SHALL be dropped; a new measurement starts only from a start edge sampled in IDLE.
REQ-022 out_valid SHALL be registered, high only in HOLD; busy = (state != IDLE), registered or decoded from state.
REQ-023 Counter arithmetic SHALL be WIDTH bits, never wrap: TIMEOUT terminates counting before overflow.
REQ-024 out_ready while not valid SHALL have no effect.

Reset
REQ-025 reset high at posedge: state IDLE, counter 0, out_valid 0, out_count 0, out_timeout 0, busy 0, both edge-history flops 0; reset has priority over every other condition.
REQ-026 Reset during COUNT or HOLD SHALL abandon the measurement with no out_valid pulse.
REQ-027 An input level already high when reset releases SHALL be detected as an edge on the first post-reset cycle.

Verification
REQ-028 Start pulse 1 cycle, stop pulse 5 cycles after start sample, out_ready=1 -> out_valid for 1 cycle, out_count=5, out_timeout=0, then IDLE.
REQ-029 Start pulse, no stop, TIMEOUT=254 -> out_valid after 254 cycles in COUNT, out_count=254, out_timeout=1; with out_ready=0 result held 20 cycles unchanged until out_ready=1.
REQ-030 Stop arriving exactly when counter+1==TIMEOUT -> out_count=254, out_timeout=0.
REQ-031 in_start held high 30 cycles, stop at cycle 10, out_ready=1 -> one result (count 10), no second measurement while in_start stays high; extra start edges in COUNT/HOLD dropped.
REQ-032 Start/stop same cycle in IDLE -> measurement starts, stop ignored; next stop 3 cycles later -> out_count=3.
REQ-033 reset asserted mid-COUNT (counter=7) -> next cycle busy=0, out_valid=0, no result; subsequent start/stop gap 4 -> out_count=4.
